// File: rtl/trap_ctrl.sv
// Trap/mret CSR sequencer: owns the single CSR write port while stepping through trap entry or return, then redirects fetch.
// Optional vectored trap targets are enabled by defining TRAP_CTRL_VECTORED_EN.
module trap_ctrl #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        excp_req_i,
    input  logic [31:0] excp_pc_i,
    input  logic [31:0] excp_cause_i,
    input  logic        mret_req_i,
    input  logic        inst_csr_we_i,
    input  logic [11:0] inst_csr_addr_i,
    input  logic [31:0] inst_csr_wdata_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic        redirect_ready_i,
    output logic        csr_we_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        pipe_stall_o
);

    typedef enum logic [2:0] {
        IDLE,
        T_MEPC,
        T_MCAUSE,
        T_MSTAT,
        R_MSTAT,
        REDIR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] target_q, target_d;

    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic [31:0] trap_mstatus;
    logic [31:0] ret_mstatus;

    assign trap_base = {mtvec_q[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
    assign trap_target = (mtvec_q[1:0] == 2'b01 && cause_q[31])
                       ? trap_base + {cause_q[29:0], 2'b00}
                       : trap_base;
`else
    logic mode_unused;
    assign mode_unused = ^mtvec_q[1:0];
    assign trap_target = trap_base;
`endif

    // Trap entry stacks MIE into MPIE; return restores it and re-arms MPIE.
    always_comb begin
        trap_mstatus        = mstatus_q;
        trap_mstatus[7]     = mstatus_q[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        ret_mstatus         = mstatus_q;
        ret_mstatus[3]      = mstatus_q[7];
        ret_mstatus[7]      = 1'b1;
        ret_mstatus[12:11]  = 2'b11;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cause_q   <= '0;
            mtvec_q   <= '0;
            mstatus_q <= '0;
            mepc_q    <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            mtvec_q   <= mtvec_d;
            mstatus_q <= mstatus_d;
            mepc_q    <= mepc_d;
            target_q  <= target_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cause_d          = cause_q;
        mtvec_d          = mtvec_q;
        mstatus_d        = mstatus_q;
        mepc_d           = mepc_q;
        target_d         = target_q;
        csr_we_o         = 1'b0;
        csr_addr_o       = '0;
        csr_wdata_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        pipe_stall_o     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (excp_req_i) begin
                    pc_d      = excp_pc_i;
                    cause_d   = excp_cause_i;
                    mtvec_d   = csr_mtvec_i;
                    mstatus_d = csr_mstatus_i;
                    state_d   = T_MEPC;
                end else if (mret_req_i) begin
                    mepc_d    = csr_mepc_i;
                    mstatus_d = csr_mstatus_i;
                    state_d   = R_MSTAT;
                end else begin
                    csr_we_o    = inst_csr_we_i;
                    csr_addr_o  = inst_csr_addr_i;
                    csr_wdata_o = inst_csr_wdata_i;
                end
            end
            T_MEPC: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = MEPC_ADDR;
                csr_wdata_o = {pc_q[31:2], 2'b00};
                state_d     = T_MCAUSE;
            end
            T_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = MCAUSE_ADDR;
                csr_wdata_o = cause_q;
                state_d     = T_MSTAT;
            end
            T_MSTAT: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = MSTATUS_ADDR;
                csr_wdata_o = trap_mstatus;
                target_d    = trap_target;
                state_d     = REDIR;
            end
            R_MSTAT: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = MSTATUS_ADDR;
                csr_wdata_o = ret_mstatus;
                target_d    = mepc_q;
                state_d     = REDIR;
            end
            REDIR: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_q;
                if (redirect_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected CSR writes and redirects are queued by the stimulus and popped by a monitor.
module tb_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        excp_req_i = 1'b0;
    logic [31:0] excp_pc_i = '0;
    logic [31:0] excp_cause_i = '0;
    logic        mret_req_i = 1'b0;
    logic        inst_csr_we_i = 1'b0;
    logic [11:0] inst_csr_addr_i = '0;
    logic [31:0] inst_csr_wdata_i = '0;
    logic [31:0] csr_mtvec_i = '0;
    logic [31:0] csr_mepc_i = '0;
    logic [31:0] csr_mstatus_i = '0;
    logic        redirect_ready_i = 1'b1;
    logic        csr_we_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        pipe_stall_o;

    int checks = 0;
    int errors = 0;

    logic [43:0] wrQ[$];
    logic [31:0] redirQ[$];

    logic [31:0] vecTarget;

    trap_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .excp_req_i       (excp_req_i),
        .excp_pc_i        (excp_pc_i),
        .excp_cause_i     (excp_cause_i),
        .mret_req_i       (mret_req_i),
        .inst_csr_we_i    (inst_csr_we_i),
        .inst_csr_addr_i  (inst_csr_addr_i),
        .inst_csr_wdata_i (inst_csr_wdata_i),
        .csr_mtvec_i      (csr_mtvec_i),
        .csr_mepc_i       (csr_mepc_i),
        .csr_mstatus_i    (csr_mstatus_i),
        .redirect_ready_i (redirect_ready_i),
        .csr_we_o         (csr_we_o),
        .csr_addr_o       (csr_addr_o),
        .csr_wdata_o      (csr_wdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .pipe_stall_o     (pipe_stall_o)
    );

    always #5 clock = ~clock;

    // Every CSR write and every accepted redirect must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (csr_we_o) begin
                checks++;
                if (wrQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write got addr=%h data=%h expected none", csr_addr_o, csr_wdata_o);
                end else begin
                    logic [43:0] exp;
                    exp = wrQ.pop_front();
                    if ({csr_addr_o, csr_wdata_o} !== exp) begin
                        errors++;
                        $display("[TB] FAIL csr_write got %h/%h expected %h/%h", csr_addr_o, csr_wdata_o, exp[43:32], exp[31:0]);
                    end
                end
            end
            if (redirect_valid_o && redirect_ready_i) begin
                checks++;
                if (redirQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_redirect got pc=%h expected none", redirect_pc_o);
                end else begin
                    logic [31:0] expPc;
                    expPc = redirQ.pop_front();
                    if (redirect_pc_o !== expPc) begin
                        errors++;
                        $display("[TB] FAIL redirect_pc got %h expected %h", redirect_pc_o, expPc);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic excp, input logic mret, input logic we,
                                 input logic [11:0] addr, input logic [31:0] data);
        @(posedge clock);
        #1;
        excp_req_i       = excp;
        mret_req_i       = mret;
        inst_csr_we_i    = we;
        inst_csr_addr_i  = addr;
        inst_csr_wdata_i = data;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic checkOutput(input string name, input logic expWe, input logic expValid,
                               input logic [31:0] expPc, input logic expStall);
        @(negedge clock);
        checks++;
        if ({csr_we_o, redirect_valid_o, redirect_pc_o, pipe_stall_o} !== {expWe, expValid, expPc, expStall}) begin
            errors++;
            $display("[TB] FAIL %s got we=%b valid=%b pc=%h stall=%b expected we=%b valid=%b pc=%h stall=%b",
                     name, csr_we_o, redirect_valid_o, redirect_pc_o, pipe_stall_o,
                     expWe, expValid, expPc, expStall);
        end
    endtask

    task automatic pushWrite(input logic [11:0] addr, input logic [31:0] data);
        wrQ.push_back({addr, data});
    endtask

    initial begin
`ifdef TRAP_CTRL_VECTORED_EN
        vecTarget = 32'h8000_021C;
`else
        vecTarget = 32'h8000_0200;
`endif
        idleCycles(2);
        checkOutput("reset_state", 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] plain instruction write");
        pushWrite(12'h305, 32'h8000_0100);
        applyStimulus(1'b0, 1'b0, 1'b1, 12'h305, 32'h8000_0100);
        checkOutput("pass_through", 1'b1, 1'b0, 32'h0, 1'b0);
        idleCycles(1);

        $display("[TB] trap sequence");
        excp_pc_i = 32'h8000_0010; excp_cause_i = 32'h0000_000B;
        csr_mtvec_i = 32'h8000_0200; csr_mstatus_i = 32'h0000_0008;
        pushWrite(12'h341, 32'h8000_0010);
        pushWrite(12'h342, 32'h0000_000B);
        pushWrite(12'h300, 32'h0000_1880);
        redirQ.push_back(32'h8000_0200);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
        checkOutput("trap_req_cycle", 1'b0, 1'b0, 32'h0, 1'b0);
        idleCycles(1);
        checkOutput("trap_mepc", 1'b1, 1'b0, 32'h0, 1'b1);
        idleCycles(1);
        checkOutput("trap_mcause", 1'b1, 1'b0, 32'h0, 1'b1);
        idleCycles(1);
        checkOutput("trap_mstatus", 1'b1, 1'b0, 32'h0, 1'b1);
        idleCycles(1);
        checkOutput("trap_redirect", 1'b0, 1'b1, 32'h8000_0200, 1'b1);
        idleCycles(1);
        checkOutput("trap_idle", 1'b0, 1'b0, 32'h0, 1'b0);

        $display("[TB] collisions");
        excp_pc_i = 32'h8000_0042; excp_cause_i = 32'h0000_0002;
        csr_mtvec_i = 32'h8000_0200; csr_mstatus_i = 32'h0000_0000;
        csr_mepc_i = 32'h1234_5678;
        pushWrite(12'h341, 32'h8000_0040);
        pushWrite(12'h342, 32'h0000_0002);
        pushWrite(12'h300, 32'h0000_1800);
        redirQ.push_back(32'h8000_0200);
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h123, 32'hDEAD_BEEF);
        checkOutput("collision_suppress", 1'b0, 1'b0, 32'h0, 1'b0);
        idleCycles(1);
        excp_pc_i = 32'h9000_0000; excp_cause_i = 32'h0000_0005;
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h456, 32'hCAFE_F00D);
        checkOutput("busy_drop", 1'b1, 1'b0, 32'h0, 1'b1);
        idleCycles(5);

        $display("[TB] mret");
        csr_mepc_i = 32'h8000_0014; csr_mstatus_i = 32'h0000_1880;
        pushWrite(12'h300, 32'h0000_1888);
        redirQ.push_back(32'h8000_0014);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h0, 32'h0);
        idleCycles(1);
        checkOutput("mret_mstatus", 1'b1, 1'b0, 32'h0, 1'b1);
        idleCycles(1);
        checkOutput("mret_redirect", 1'b0, 1'b1, 32'h8000_0014, 1'b1);
        idleCycles(1);
        checkOutput("mret_idle", 1'b0, 1'b0, 32'h0, 1'b0);

        $display("[TB] redirect backpressure");
        redirect_ready_i = 1'b0;
        csr_mepc_i = 32'h8000_0100; csr_mstatus_i = 32'h0000_0000;
        pushWrite(12'h300, 32'h0000_1880);
        redirQ.push_back(32'h8000_0100);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h0, 32'h0);
        idleCycles(1);
        for (int i = 0; i < 5; i++) begin
            idleCycles(1);
            checkOutput("backpressure_hold", 1'b0, 1'b1, 32'h8000_0100, 1'b1);
        end
        idleCycles(1);
        redirect_ready_i = 1'b1;
        checkOutput("backpressure_accept", 1'b0, 1'b1, 32'h8000_0100, 1'b1);
        idleCycles(1);
        checkOutput("backpressure_idle", 1'b0, 1'b0, 32'h0, 1'b0);

        $display("[TB] reset mid-sequence");
        excp_pc_i = 32'h8000_0020; excp_cause_i = 32'h0000_0003;
        csr_mtvec_i = 32'h8000_0300; csr_mstatus_i = 32'h0000_0008;
        pushWrite(12'h341, 32'h8000_0020);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
        idleCycles(2);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        checkOutput("reset_mid", 1'b0, 1'b0, 32'h0, 1'b0);
        idleCycles(5);

        $display("[TB] vectored target");
        excp_pc_i = 32'h8000_0080; excp_cause_i = 32'h8000_0007;
        csr_mtvec_i = 32'h8000_0201; csr_mstatus_i = 32'h0000_0000;
        pushWrite(12'h341, 32'h8000_0080);
        pushWrite(12'h342, 32'h8000_0007);
        pushWrite(12'h300, 32'h0000_1800);
        redirQ.push_back(vecTarget);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
        idleCycles(3);
        idleCycles(1);
        checkOutput("vector_redirect", 1'b0, 1'b1, vecTarget, 1'b1);
        idleCycles(3);

        checks++;
        if (wrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_writes got %0d left expected 0", wrQ.size());
        end
        checks++;
        if (redirQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_redirects got %0d left expected 0", redirQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences CSR-file updates for traps and `mret` through the single CSR write port downstream of writeback.
- Arbitrates that port between ordinary instruction CSR writes from writeback and its own multi-cycle trap/return sequence.
- Stalls the pipeline while sequencing, then issues a redirect to fetch with a ready handshake.

Parameters:
- MSTATUS_ADDR, 12'h300, CSR address of mstatus
- MEPC_ADDR, 12'h341, CSR address of mepc
- MCAUSE_ADDR, 12'h342, CSR address of mcause

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- excp_req_i  input  1  exception commit request (one-cycle pulse)
- excp_pc_i  input  32  PC of the excepting instruction
- excp_cause_i  input  32  mcause value
- mret_req_i  input  1  mret commit request (one-cycle pulse)
- inst_csr_we_i  input  1  instruction CSR write enable from writeback
- inst_csr_addr_i  input  12  instruction CSR address
- inst_csr_wdata_i  input  32  instruction CSR write data
- csr_mtvec_i  input  32  current mtvec
- csr_mepc_i  input  32  current mepc
- csr_mstatus_i  input  32  current mstatus
- redirect_ready_i  input  1  fetch accepts redirect
- csr_we_o  output  1  CSR write enable to CSR file
- csr_addr_o  output  12  CSR write address
- csr_wdata_o  output  32  CSR write data
- redirect_valid_o  output  1  redirect request to fetch
- redirect_pc_o  output  32  redirect target
- pipe_stall_o  output  1  high while the block owns the port or is redirecting

Behaviour:
- **States:** IDLE, T_MEPC, T_MCAUSE, T_MSTAT, R_MSTAT, REDIR.
- **Reset:** synchronous; state forced to IDLE. All outputs are 0 in the cycle after reset is asserted, including reset asserted mid-sequence. Latched registers are cleared to 0.
- **IDLE, arbitration:**
  - If `excp_req_i`: latch pc, cause, mtvec, mstatus; go to T_MEPC. The same-cycle instruction write is suppressed.
  - Else if `mret_req_i`: latch mepc, mstatus; go to R_MSTAT. The same-cycle instruction write is suppressed.
  - Else the instruction write passes through combinationally: `csr_we_o = inst_csr_we_i`, with addr and data passed through.
- **Priority:** exception beats mret beats instruction write.
- **T_MEPC:** we=1, addr=MEPC_ADDR, data={pc[31:2],2'b00}; next T_MCAUSE.
- **T_MCAUSE:** we=1, addr=MCAUSE_ADDR, data=cause; next T_MSTAT.
- **T_MSTAT:** we=1, addr=MSTATUS_ADDR, data=latched mstatus with:
  - MPIE[7] <= MIE[3]
  - MIE[3] <= 0
  - MPP[12:11] <= 2'b11
  - all other bits unchanged
  - Set target = {mtvec[31:2],2'b00}; next REDIR.
- **R_MSTAT:** we=1, addr=MSTATUS_ADDR, data=latched mstatus with:
  - MIE[3] <= MPIE[7]
  - MPIE[7] <= 1
  - MPP <= 2'b11
  - Set target = latched mepc; next REDIR.
- **REDIR:**
  - `redirect_valid_o` = 1 and `redirect_pc_o` = target, both held stable until `redirect_ready_i`.
  - On ready: next IDLE; valid drops the following cycle.
  - csr_we_o = 0.
- **Stall:** `pipe_stall_o` = 1 in every non-IDLE state; 0 in IDLE.
- **Busy handling:** in all non-IDLE states, `excp_req_i`, `mret_req_i` and `inst_csr_we_i` are ignored and dropped, not queued; those instructions belong to the flushed path.
- **Latency:**
  - Trap: request at cycle N, mepc write at N+1, mcause at N+2, mstatus at N+3, redirect valid from N+4.
  - mret: mstatus write at N+1, redirect from N+2.
- **Outputs in IDLE:** redirect_pc_o = 0.

Optional Feature:
- Macro: `TRAP_CTRL_VECTORED_EN`.
- **Defined:** when mtvec[1:0]==2'b01 and cause[31]==1, trap target = {mtvec[31:2],2'b00} + {cause[29:0],2'b00}. All other cases use the base address.
- **Undefined:** mtvec[1:0] is ignored and the target is always the base address. mret is unaffected either way.

Test Plan:
- **Plain instruction write:** IDLE, inst_csr_we_i=1, addr=12'h305, data=32'h8000_0100 -> same cycle csr_we_o=1 with that addr/data; pipe_stall_o=0.
- **Trap sequence:** excp_req_i with pc=32'h8000_0010, cause=32'h0000_000B, mtvec=32'h8000_0200, mstatus=32'h0000_0008 -> N+1 write 341/8000_0010; N+2 write 342/0000_000B; N+3 write 300/0000_1880; N+4 redirect_valid_o=1, pc=32'h8000_0200.
- **mret:** mepc=32'h8000_0014, mstatus=32'h0000_1880, mret_req_i -> N+1 write 300/0000_1888; N+2 redirect to 32'h8000_0014.
- **Collisions:** excp_req_i, mret_req_i and inst_csr_we_i in the same cycle -> trap sequence only; no write of the instruction data. During T_MCAUSE, a second excp_req_i -> ignored; only 3 CSR writes and 1 redirect occur.
- **Redirect backpressure:** redirect_ready_i=0 for 5 cycles -> redirect_valid_o and pc held stable and pipe_stall_o=1 throughout. Ready=1 -> IDLE next cycle with all outputs 0.
- **Reset mid-sequence, and vectored mode:**
  - Reset asserted in T_MCAUSE -> next cycle IDLE, csr_we_o=0, pipe_stall_o=0, no redirect.
  - With TRAP_CTRL_VECTORED_EN: mtvec=32'h8000_0201, cause=32'h8000_0007 -> target 32'h8000_021C.
  - Without TRAP_CTRL_VECTORED_EN, same mtvec and cause -> target 32'h8000_0200.
